// File: rtl/nsnr_flag_bank.sv
// N-channel synchronous set/reset flag register with active-low requests,
// optional input synchronisers, selectable collision rule and level/edge set.
module nsnr_flag_bank #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRIO        = 0,
  parameter int unsigned EDGE_SET    = 0
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic [N-1:0]           nset,
  input  logic [N-1:0]           nclr,
  output logic [N-1:0]           q,
  output logic [N-1:0]           nq,
  output logic [N-1:0]           rose,
  output logic                   any,
  output logic [$clog2(N+1)-1:0] cnt
);

  localparam int unsigned CW = $clog2(N+1);

  typedef enum logic [1:0] {
    CLR_WINS = 2'd0,
    SET_WINS = 2'd1,
    TOGGLE   = 2'd2
  } prio_e;

  localparam prio_e RULE = prio_e'(PRIO[1:0]);

  logic [N-1:0] nset_s;
  logic [N-1:0] nclr_s;
  logic [N-1:0] prev_nset;
  logic [N-1:0] s_set;
  logic [N-1:0] s_clr;
  logic [N-1:0] set_req;
  logic [N-1:0] q_next;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [N-1:0] set_pipe [SYNC_STAGES];
      logic [N-1:0] clr_pipe [SYNC_STAGES];

      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            set_pipe[i] <= '1;
            clr_pipe[i] <= '1;
          end
        end else begin
          set_pipe[0] <= nset;
          clr_pipe[0] <= nclr;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            set_pipe[i] <= set_pipe[i-1];
            clr_pipe[i] <= clr_pipe[i-1];
          end
        end
      end

      assign nset_s = set_pipe[SYNC_STAGES-1];
      assign nclr_s = clr_pipe[SYNC_STAGES-1];
    end else begin : g_nosync
      assign nset_s = nset;
      assign nclr_s = nclr;
    end
  endgenerate

  // History is kept in nset polarity so its reset value of all ones means
  // "previously inactive": a set held across reset release yields one edge.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      prev_nset <= '1;
    end else begin
      prev_nset <= nset_s;
    end
  end

  assign s_set   = ~nset_s;
  assign s_clr   = ~nclr_s;
  assign set_req = (EDGE_SET != 0) ? (s_set & prev_nset) : s_set;

  always_comb begin
    q_next = q;
    for (int unsigned i = 0; i < N; i++) begin
      if (set_req[i] && s_clr[i]) begin
        case (RULE)
          CLR_WINS: q_next[i] = 1'b0;
          SET_WINS: q_next[i] = 1'b1;
          default:  q_next[i] = ~q[i];
        endcase
      end else if (set_req[i]) begin
        q_next[i] = 1'b1;
      end else if (s_clr[i]) begin
        q_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q    <= '0;
      rose <= '0;
    end else begin
      q    <= q_next;
      rose <= q_next & ~q;
    end
  end

  assign nq  = ~q;
  assign any = |q;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + CW'(q[i]);
    end
  end

endmodule

// File: tb/tb_nsnr_flag_bank.sv
// Directed bench for nsnr_flag_bank: four instances share one stimulus stream
// (clear-wins, set-wins, toggle, edge-set) and each phase checks the relevant one.
module tb_nsnr_flag_bank;

  logic       ck = 1'b0;
  logic       rst;
  logic [3:0] nset;
  logic [3:0] nclr;

  logic [3:0] qa, nqa, ra; logic aa; logic [2:0] ca;
  logic [3:0] qb, nqb, rb; logic ab; logic [2:0] cb;
  logic [3:0] qc, nqc, rc; logic ac; logic [2:0] cc;
  logic [3:0] qd, nqd, rd; logic ad; logic [2:0] cd;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  nsnr_flag_bank #(.N(4), .SYNC_STAGES(2), .PRIO(0), .EDGE_SET(0)) u_a (
    .ck(ck), .rst(rst), .nset(nset), .nclr(nclr),
    .q(qa), .nq(nqa), .rose(ra), .any(aa), .cnt(ca));

  nsnr_flag_bank #(.N(4), .SYNC_STAGES(2), .PRIO(1), .EDGE_SET(0)) u_b (
    .ck(ck), .rst(rst), .nset(nset), .nclr(nclr),
    .q(qb), .nq(nqb), .rose(rb), .any(ab), .cnt(cb));

  nsnr_flag_bank #(.N(4), .SYNC_STAGES(2), .PRIO(2), .EDGE_SET(0)) u_c (
    .ck(ck), .rst(rst), .nset(nset), .nclr(nclr),
    .q(qc), .nq(nqc), .rose(rc), .any(ac), .cnt(cc));

  nsnr_flag_bank #(.N(4), .SYNC_STAGES(2), .PRIO(0), .EDGE_SET(1)) u_d (
    .ck(ck), .rst(rst), .nset(nset), .nclr(nclr),
    .q(qd), .nq(nqd), .rose(rd), .any(ad), .cnt(cd));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    nset = 4'h0;
    nclr = 4'hF;

    // Reset state, before any clock edge
    #2;
    chk("rst_qa", qa, 4'h0);   chk("rst_nqa", nqa, 4'hF);
    chk("rst_ra", ra, 4'h0);   chk("rst_aa", aa, 1'b0);   chk("rst_ca", ca, 3'd0);
    chk("rst_qb", qb, 4'h0);   chk("rst_nqb", nqb, 4'hF);
    chk("rst_rb", rb, 4'h0);   chk("rst_ab", ab, 1'b0);   chk("rst_cb", cb, 3'd0);
    chk("rst_qc", qc, 4'h0);   chk("rst_nqc", nqc, 4'hF);
    chk("rst_rc", rc, 4'h0);   chk("rst_ac", ac, 1'b0);   chk("rst_cc", cc, 3'd0);
    chk("rst_qd", qd, 4'h0);   chk("rst_nqd", nqd, 4'hF);
    chk("rst_rd", rd, 4'h0);   chk("rst_ad", ad, 1'b0);   chk("rst_cd", cd, 3'd0);
    tick(); tick();
    chk("rst_hold_qa", qa, 4'h0); chk("rst_hold_ca", ca, 3'd0);

    // Release with nset held low: q=F on the 3rd edge
    rst = 1'b0;
    tick(); tick();
    chk("rel_e2_qa", qa, 4'h0);
    chk("rel_e2_qd", qd, 4'h0);
    tick();
    chk("rel_e3_qa", qa, 4'hF);  chk("rel_e3_ra", ra, 4'hF);
    chk("rel_e3_ca", ca, 3'd4);  chk("rel_e3_aa", aa, 1'b1);
    chk("rel_e3_nqa", nqa, 4'h0);
    chk("rel_e3_qd", qd, 4'hF);  chk("rel_e3_rd", rd, 4'hF);
    tick();
    chk("rel_e4_qa", qa, 4'hF);  chk("rel_e4_ra", ra, 4'h0);
    chk("rel_e4_qd", qd, 4'hF);  chk("rel_e4_rd", rd, 4'h0);

    // Clear everything
    nset = 4'hF; nclr = 4'h0;
    tick();
    nclr = 4'hF;
    tick(); tick();
    chk("clr_qa", qa, 4'h0); chk("clr_qb", qb, 4'h0);
    chk("clr_qc", qc, 4'h0); chk("clr_qd", qd, 4'h0);
    chk("clr_ra", ra, 4'h0);

    // Latency: one-cycle set pulse on channel 1
    nset = 4'b1101;
    tick();
    nset = 4'hF;
    tick();
    chk("lat_e2_qa", qa, 4'h0);
    tick();
    chk("lat_e3_qa", qa, 4'h2); chk("lat_e3_ra", ra, 4'h2); chk("lat_e3_ca", ca, 3'd1);
    tick();
    chk("lat_e4_qa", qa, 4'h2); chk("lat_e4_ra", ra, 4'h0);
    repeat (3) tick();
    chk("lat_hold_qa", qa, 4'h2);

    nclr = 4'b1101;
    tick();
    nclr = 4'hF;
    tick();
    chk("lclr_e2_qa", qa, 4'h2);
    tick();
    chk("lclr_e3_qa", qa, 4'h0); chk("lclr_e3_ra", ra, 4'h0);

    // Collision on channel 0
    nset = 4'b1110; nclr = 4'b1110;
    tick(); tick();
    chk("col_e2_qc", qc, 4'h0);
    tick();
    chk("col_e3_qa", qa, 4'h0); chk("col_e3_qb", qb, 4'h1); chk("col_e3_qc", qc, 4'h1);
    chk("col_e3_rb", rb, 4'h1);
    tick();
    chk("col_e4_qa", qa, 4'h0); chk("col_e4_qb", qb, 4'h1); chk("col_e4_qc", qc, 4'h0);
    chk("col_e4_rb", rb, 4'h0);
    tick();
    chk("col_e5_qc", qc, 4'h1); chk("col_e5_rc", rc, 4'h1);

    nset = 4'hF; nclr = 4'hF;
    repeat (3) tick();
    nclr = 4'h0;
    tick();
    nclr = 4'hF;
    repeat (3) tick();
    chk("col_clr_qa", qa, 4'h0); chk("col_clr_qb", qb, 4'h0);
    chk("col_clr_qc", qc, 4'h0); chk("col_clr_qd", qd, 4'h0);

    // Edge-triggered set on channel 2
    nset = 4'b1011;
    repeat (3) tick();
    chk("edge_set_qd", qd, 4'h4); chk("edge_set_rd", rd, 4'h4);
    nclr = 4'b1011;
    tick();
    nclr = 4'hF;
    tick();
    chk("edge_clr_e2_qd", qd, 4'h4);
    tick();
    chk("edge_clr_e3_qd", qd, 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("edge_hold_qd", qd, 4'h0);
    end
    nset = 4'hF;
    repeat (4) tick();
    nset = 4'b1011;
    tick(); tick();
    chk("edge_re_e2_qd", qd, 4'h0);
    tick();
    chk("edge_re_e3_qd", qd, 4'h4); chk("edge_re_e3_rd", rd, 4'h4);
    tick();
    chk("edge_re_e4_qd", qd, 4'h4); chk("edge_re_e4_rd", rd, 4'h0);

    // Simultaneous channel events from q=0001
    nset = 4'hF;
    repeat (3) tick();
    nclr = 4'h0;
    tick();
    nclr = 4'hF;
    repeat (3) tick();
    chk("sim_pre_clr_qa", qa, 4'h0);
    nset = 4'b1110;
    tick();
    nset = 4'hF;
    tick(); tick();
    chk("sim_pre_qa", qa, 4'h1);
    nset = 4'b0101; nclr = 4'b1110;
    tick();
    nset = 4'hF; nclr = 4'hF;
    tick();
    chk("sim_e2_qa", qa, 4'h1);
    tick();
    chk("sim_qa", qa, 4'hA); chk("sim_ra", ra, 4'hA);
    chk("sim_ca", ca, 3'd2); chk("sim_aa", aa, 1'b1); chk("sim_nqa", nqa, 4'h5);

    // Asynchronous reset mid-operation
    nset = 4'h0;
    repeat (3) tick();
    chk("ar_pre_qa", qa, 4'hF); chk("ar_pre_ca", ca, 3'd4);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_qa", qa, 4'h0);  chk("ar_nqa", nqa, 4'hF);
    chk("ar_ca", ca, 3'd0);  chk("ar_aa", aa, 1'b0);
    chk("ar_ra", ra, 4'h0);  chk("ar_qd", qd, 4'h0);
    nset = 4'hF;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ar_post_qa", qa, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nsnr_flag_bank.md
Name: nsnr_flag_bank

Overview:
- Clocked, parametrised successor to the asynchronous NAND set/reset latch: N independent set/reset flag channels.
- Active-low set and clear inputs, optional input synchronisers, selectable collision resolution (including toggle), and a level- or edge-triggered set mode.
- Provides per-channel q/nq, a one-cycle rise pulse, and any-set and set-count summaries.
- Sits between asynchronous event sources (fault/ready strobes) and digital control logic as a glitch-free, synchronous flag register.

Parameters:
- N, 4, number of flag channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per nset/nclr bit (0 = inputs already synchronous, sampled directly).
- PRIO, 0, collision rule when set and clear are both active: 0 = clear wins, 1 = set wins, 2 = toggle.
- EDGE_SET, 0, 0 = level set (set while nset low), 1 = set only on synchronised high-to-low transition of nset.

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- nset  input  N  active-low set request per channel.
- nclr  input  N  active-low clear request per channel (always level-sensitive).
- q  output  N  flag state.
- nq  output  N  complement of q, always exactly ~q, never both high.
- rose  output  N  one-cycle pulse when q[i] goes 0->1.
- any  output  1  OR of q.
- cnt  output  $clog2(N+1)  number of set bits in q.

Behaviour:
- Clock and reset: one clock, ck. rst is asynchronous, active-high; all flops clear immediately on assertion and release on the next ck edge after deassertion.
- Reset values:
  - synchroniser flops and the edge-detect history = 1 (inactive);
  - q = 0, nq = all ones, rose = 0, any = 0, cnt = 0.
- Synchronisers: per bit, SYNC_STAGES flops in series give synchronised signals s_set = ~nset_sync and s_clr = ~nclr_sync. With SYNC_STAGES=0, s_set = ~nset and s_clr = ~nclr.
- Set request:
  - EDGE_SET=0: set_req = s_set.
  - EDGE_SET=1: set_req = s_set & ~prev_s_set, where prev_s_set is a register updated every cycle.
  - nset held low across reset release produces exactly one edge in EDGE_SET=1.
- Next state per channel, registered on ck:
  - set_req only -> 1; s_clr only -> 0; neither -> hold.
  - both active: PRIO 0 -> 0; PRIO 1 -> 1; PRIO 2 -> ~q.
  - PRIO 2 with a level set held toggles every cycle for as long as both requests stay active.
- Latency: an input change reaches q after SYNC_STAGES+1 rising edges.
- rose[i]: registered, high for exactly the cycle in which q[i] first reads 1 after being 0. Set-while-set gives no pulse.
- nq, any, cnt: combinational from registered q, so they are glitch-free relative to q and valid in the same cycle as q.
- Channels are fully independent; simultaneous events on different channels are all applied in the same cycle.
- Reset mid-operation: all state is lost, including in-flight synchroniser contents. After release, requests still being held are re-sampled from scratch, with the full latency.
- cnt: maximum value N, no wrap; width is sufficient by construction.

Test Plan:
- Reset: drive rst=1 with nset=4'b0000 -> q=0, nq=4'hF, any=0, cnt=0 throughout. Release, default parameters -> q=4'hF on the 3rd edge, rose=4'hF for 1 cycle, cnt=4.
- Latency/hold: N=4, SYNC_STAGES=2, pulse nset[1] low for 1 cycle -> q=4'b0010 exactly 3 edges later and held. Then pulse nclr[1] -> q=0 after 3 edges, rose stays 0.
- Collision, PRIO=0/1/2: hold nset[0]=0 and nclr[0]=0 together -> PRIO 0: q[0]=0; PRIO 1: q[0]=1; PRIO 2: q[0] alternates 1,0,1,... each cycle.
- EDGE_SET=1: hold nset[2] low for 10 cycles after clearing with a nclr[2] pulse -> q[2] stays 0 (no new edge). Release nset[2] and drive it low again -> q[2]=1, rose[2] pulses once.
- Simultaneous channels: nset=4'b0101 and nclr=4'b1110 applied together from q=4'b0001 -> q=4'b1010, rose=4'b1010, cnt=2, any=1.
- Async reset mid-operation: assert rst between ck edges while q=4'hF -> q=0 immediately, without waiting for ck. nset is released before rst release, so it has gone high by then -> q stays 0 after release.
